lock_attempt_ctrl: RTL and testbench
====================================

// Module: lock_attempt_ctrl
// PURPOSE
//  Supervisor above the digit-entry controller of the combination lock.
//  - Takes each completed code from the entry shift register and checks it against the stored code.
//  - Counts failed attempts and enforces a timed lockout after MAX_TRIES failures.
//  - Auto-relocks after an idle timeout and supports reprogramming the code while unlocked.
//  - Pulses restart_o so the entry controller re-arms for the next code.
// PARAMETERS
//  DIGITS          4        number of digits in a code
//  DIGIT_W         4        bits per digit; CODE_W = DIGITS*DIGIT_W
//  MAX_TRIES       3        consecutive failures that trigger lockout (>=1)
//  LOCKOUT_CYCLES  1000     lockout duration in clk_i cycles (>=2)
//  UNLOCK_CYCLES   500      auto-relock timeout in UNLOCKED, in cycles (>=2)
//  DEFAULT_CODE    16'h1234 stored code after reset (CODE_W bits)
// PORTS
//  clk_i        in   1               system clock, all logic on rising edge
//  rst_i        in   1               synchronous reset, active-high
//  entered_i    in   1               1-cycle pulse: last digit accepted, code_i valid this cycle
//  code_i       in   CODE_W          completed code from entry shift register
//  lock_i       in   1               relock request (level, sampled each cycle)
//  program_i    in   1               request to enter code-change mode (level)
//  unlocked_o   out  1               high in UNLOCKED and PROGRAM
//  lockout_o    out  1               high in LOCKOUT
//  fail_cnt_o   out  $clog2(MAX_TRIES+1)  current consecutive-failure count
//  restart_o    out  1               1-cycle pulse: re-arm entry controller
// BEHAVIOUR
//  - Clocking/reset: one clock; reset is synchronous and active-high.
//  - Reset values:
//    - state=LOCKED, stored code=DEFAULT_CODE, fail_cnt=0, timer=0.
//    - unlocked_o=0, lockout_o=0, restart_o=0.
//    - rst_i at any time, including mid-LOCKOUT or mid-PROGRAM, reverts the code to DEFAULT_CODE.
//  - Outputs: all registered (Moore). restart_o is high only in the first cycle after entering LOCKED or PROGRAM.
//  - LOCKED: entered_i -> latch code_i into cand register, go to CHECK. lock_i and program_i are ignored.
//  - CHECK (exactly 1 cycle; entered_i ignored):
//    - cand==stored -> UNLOCKED; fail_cnt:=0; timer:=UNLOCK_CYCLES-1.
//    - mismatch, fail_cnt+1<MAX_TRIES -> LOCKED; fail_cnt+=1; restart_o.
//    - mismatch, fail_cnt+1==MAX_TRIES -> LOCKOUT; fail_cnt:=MAX_TRIES; timer:=LOCKOUT_CYCLES-1.
//  - Latency: entered_i high in cycle N -> unlocked_o or lockout_o high from cycle N+2.
//  - UNLOCKED: timer decrements each cycle. Priority, highest first:
//    - lock_i -> LOCKED + restart_o.
//    - program_i -> PROGRAM + restart_o.
//    - timer==0 -> LOCKED + restart_o.
//    - entered_i ignored.
//  - PROGRAM (no timeout):
//    - lock_i -> LOCKED, stored unchanged. lock_i beats a same-cycle entered_i.
//    - otherwise entered_i -> stored:=code_i, then LOCKED + restart_o.
//  - LOCKOUT: timer decrements; entered_i, lock_i and program_i are ignored. timer==0 -> LOCKED; fail_cnt:=0; restart_o.
//  - Timer: width $clog2(max(LOCKOUT_CYCLES,UNLOCK_CYCLES)). Never wraps: it is reloaded on state entry and only compared to 0.
//  - fail_cnt saturates at MAX_TRIES and never wraps.
//  - Dwell times: UNLOCKED lasts exactly UNLOCK_CYCLES cycles with no lock_i/program_i; LOCKOUT lasts exactly LOCKOUT_CYCLES.
//  - entered_i held more than 1 cycle is a protocol error; only the first cycle is acted on, because CHECK ignores the input.
// TESTING (MAX_TRIES=3, LOCKOUT_CYCLES=8, UNLOCK_CYCLES=16, DEFAULT_CODE=16'h1234)
//  1. rst_i, then entered_i with code_i=1234 at cycle N
//     -> unlocked_o=1 from N+2; fail_cnt_o=0; restart_o stays 0.
//  2. Three entered_i with code_i=0000
//     -> fail_cnt_o 1, 2, then lockout_o=1 for exactly 8 cycles.
//     -> entered_i with 1234 during lockout ignored; on exit fail_cnt_o=0 and one restart_o pulse.
//  3. Unlock with 1234, drive nothing
//     -> unlocked_o high exactly 16 cycles, then 0 with one restart_o pulse.
//  4. Unlock, program_i=1, then entered_i with 5678
//     -> LOCKED; entering 1234 fails (fail_cnt_o=1); entering 5678 unlocks and clears fail_cnt_o.
//  5. In UNLOCKED, lock_i=program_i=1 in the same cycle
//     -> LOCKED, stored code unchanged (1234 still unlocks).
//  6. Two failures, then rst_i during a third-failure lockout
//     -> LOCKED, fail_cnt_o=0, lockout_o=0, stored code back to 1234.

Source files
------------

// File: rtl/lock_attempt_ctrl_if.sv
// Signal bundle between the lock supervisor and its user: code-entry handshake in,
// lock status out. The master drives requests; the slave is the supervisor.
interface lock_attempt_ctrl_if #(
  parameter int DIGITS    = 4,
  parameter int DIGIT_W   = 4,
  parameter int MAX_TRIES = 3
);
  localparam int CODE_W = DIGITS * DIGIT_W;
  localparam int FAIL_W = $clog2(MAX_TRIES + 1);

  logic              entered_i;
  logic [CODE_W-1:0] code_i;
  logic              lock_i;
  logic              program_i;
  logic              unlocked_o;
  logic              lockout_o;
  logic [FAIL_W-1:0] fail_cnt_o;
  logic              restart_o;

  modport master (
    output entered_i, code_i, lock_i, program_i,
    input  unlocked_o, lockout_o, fail_cnt_o, restart_o
  );

  modport slave (
    input  entered_i, code_i, lock_i, program_i,
    output unlocked_o, lockout_o, fail_cnt_o, restart_o
  );
endinterface

// File: rtl/lock_attempt_ctrl.sv
// Combination-lock supervisor: checks entered codes, counts failures, enforces a timed
// lockout, auto-relocks after idling and lets the code be changed while unlocked.
module lock_attempt_ctrl #(
  parameter int                         DIGITS         = 4,
  parameter int                         DIGIT_W        = 4,
  parameter int                         MAX_TRIES      = 3,
  parameter int                         LOCKOUT_CYCLES = 1000,
  parameter int                         UNLOCK_CYCLES  = 500,
  parameter logic [DIGITS*DIGIT_W-1:0]  DEFAULT_CODE   = 16'h1234
) (
  input  logic                clk_i,
  input  logic                rst_i,
  lock_attempt_ctrl_if.slave  bus
);
  localparam int CODE_W  = DIGITS * DIGIT_W;
  localparam int FAIL_W  = $clog2(MAX_TRIES + 1);
  localparam int TMAX    = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ? LOCKOUT_CYCLES : UNLOCK_CYCLES;
  localparam int TIMER_W = $clog2(TMAX);

  localparam logic [FAIL_W-1:0]  MAX_CNT    = FAIL_W'(MAX_TRIES);
  localparam logic [FAIL_W-1:0]  LAST_CNT   = FAIL_W'(MAX_TRIES - 1);
  localparam logic [TIMER_W-1:0] UNLOCK_LD  = TIMER_W'(UNLOCK_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCKOUT_LD = TIMER_W'(LOCKOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_LOCKED,
    S_CHECK,
    S_UNLOCKED,
    S_PROGRAM,
    S_LOCKOUT
  } state_t;

  state_t              r_state;
  logic [CODE_W-1:0]   r_stored;
  logic [CODE_W-1:0]   r_cand;
  logic [FAIL_W-1:0]   r_failCnt;
  logic [TIMER_W-1:0]  r_timer;
  logic                r_unlocked;
  logic                r_lockout;
  logic                r_restart;

  logic                w_match;
  logic                w_lastTry;
  logic                w_timerZero;

  assign w_match     = (r_cand == r_stored);
  assign w_lastTry   = (r_failCnt == LAST_CNT);
  assign w_timerZero = (r_timer == '0);

  // Timers are reloaded on entry and only tested for zero, so the dwell is load+1 cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_LOCKED;
      r_stored   <= DEFAULT_CODE;
      r_cand     <= '0;
      r_failCnt  <= '0;
      r_timer    <= '0;
      r_unlocked <= 1'b0;
      r_lockout  <= 1'b0;
      r_restart  <= 1'b0;
    end else begin
      r_restart <= 1'b0;
      unique case (r_state)
        S_LOCKED: begin
          if (bus.entered_i) begin
            r_cand  <= bus.code_i;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_match) begin
            r_state    <= S_UNLOCKED;
            r_failCnt  <= '0;
            r_timer    <= UNLOCK_LD;
            r_unlocked <= 1'b1;
          end else if (w_lastTry) begin
            r_state   <= S_LOCKOUT;
            r_failCnt <= MAX_CNT;
            r_timer   <= LOCKOUT_LD;
            r_lockout <= 1'b1;
          end else begin
            r_state   <= S_LOCKED;
            r_failCnt <= r_failCnt + FAIL_W'(1);
            r_restart <= 1'b1;
          end
        end
        S_UNLOCKED: begin
          if (bus.lock_i || (!bus.program_i && w_timerZero)) begin
            r_state    <= S_LOCKED;
            r_unlocked <= 1'b0;
            r_restart  <= 1'b1;
          end else if (bus.program_i) begin
            r_state   <= S_PROGRAM;
            r_restart <= 1'b1;
          end else begin
            r_timer <= r_timer - TIMER_W'(1);
          end
        end
        // A relock request abandons programming without touching the stored code.
        S_PROGRAM: begin
          if (bus.lock_i || bus.entered_i) begin
            if (!bus.lock_i) begin
              r_stored <= bus.code_i;
            end
            r_state    <= S_LOCKED;
            r_unlocked <= 1'b0;
            r_restart  <= 1'b1;
          end
        end
        S_LOCKOUT: begin
          if (w_timerZero) begin
            r_state   <= S_LOCKED;
            r_lockout <= 1'b0;
            r_failCnt <= '0;
            r_restart <= 1'b1;
          end else begin
            r_timer <= r_timer - TIMER_W'(1);
          end
        end
        default: begin
          r_state <= S_LOCKED;
        end
      endcase
    end
  end

  assign bus.unlocked_o = r_unlocked;
  assign bus.lockout_o  = r_lockout;
  assign bus.fail_cnt_o = r_failCnt;
  assign bus.restart_o  = r_restart;
endmodule

// File: tb/tb_lock_attempt_ctrl.sv
// Directed bench for lock_attempt_ctrl: a vector table for single-cycle behaviour plus
// hand-written sequences for lockout, auto-relock dwell and reset-time code revert.
module tb_lock_attempt_ctrl;
  localparam int DIGITS         = 4;
  localparam int DIGIT_W        = 4;
  localparam int MAX_TRIES      = 3;
  localparam int LOCKOUT_CYCLES = 8;
  localparam int UNLOCK_CYCLES  = 16;

  typedef struct {
    logic        entered;
    logic [15:0] code;
    logic        lock;
    logic        prog;
    logic        expU;
    logic        expL;
    logic [1:0]  expF;
    logic        expR;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  vec_t vecs[$];

  lock_attempt_ctrl_if #(
    .DIGITS   (DIGITS),
    .DIGIT_W  (DIGIT_W),
    .MAX_TRIES(MAX_TRIES)
  ) bus ();

  lock_attempt_ctrl #(
    .DIGITS        (DIGITS),
    .DIGIT_W       (DIGIT_W),
    .MAX_TRIES     (MAX_TRIES),
    .LOCKOUT_CYCLES(LOCKOUT_CYCLES),
    .UNLOCK_CYCLES (UNLOCK_CYCLES),
    .DEFAULT_CODE  (16'h1234)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic applyStimulus(input logic e, input logic [15:0] c, input logic lk, input logic pg);
    @(negedge clk);
    bus.entered_i = e;
    bus.code_i    = c;
    bus.lock_i    = lk;
    bus.program_i = pg;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic u, input logic l, input logic [1:0] f,
                             input logic r);
    checks++;
    if (bus.unlocked_o !== u || bus.lockout_o !== l || bus.fail_cnt_o !== f || bus.restart_o !== r) begin
      errors++;
      $display("[TB] FAIL %s: got u=%b l=%b f=%0d r=%b, expected u=%b l=%b f=%0d r=%b", name,
               bus.unlocked_o, bus.lockout_o, bus.fail_cnt_o, bus.restart_o, u, l, f, r);
    end
  endtask

  task automatic checkValue(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic addVec(input logic e, input logic [15:0] c, input logic lk, input logic pg,
                        input logic u, input logic l, input logic [1:0] f, input logic r);
    vec_t v;
    v.entered = e; v.code = c; v.lock = lk; v.prog = pg;
    v.expU = u; v.expL = l; v.expF = f; v.expR = r;
    vecs.push_back(v);
  endtask

  initial begin
    int  cnt;
    bit  done;

    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.entered_i = 1'b0;
    bus.code_i    = '0;
    bus.lock_i    = 1'b0;
    bus.program_i = 1'b0;

    // Expected outputs after each vector's clock edge; stored code starts at 1234.
    addVec(1, 16'h1234, 0, 0,  0, 0, 0, 0);  // 0  LOCKED -> CHECK
    addVec(0, 16'h0000, 0, 0,  1, 0, 0, 0);  // 1  match -> UNLOCKED, no restart
    addVec(0, 16'h0000, 1, 1,  0, 0, 0, 1);  // 2  lock beats program
    addVec(0, 16'h0000, 0, 0,  0, 0, 0, 0);  // 3  restart is one cycle
    addVec(1, 16'h1234, 0, 0,  0, 0, 0, 0);  // 4  code unchanged
    addVec(0, 16'h0000, 0, 0,  1, 0, 0, 0);  // 5
    addVec(0, 16'h0000, 0, 1,  1, 0, 0, 1);  // 6  -> PROGRAM
    addVec(1, 16'h5678, 0, 1,  0, 0, 0, 1);  // 7  store 5678 -> LOCKED
    addVec(1, 16'h1234, 0, 0,  0, 0, 0, 0);  // 8  old code
    addVec(0, 16'h0000, 0, 0,  0, 0, 1, 1);  // 9  fails
    addVec(1, 16'h5678, 0, 0,  0, 0, 1, 0);  // 10 new code
    addVec(0, 16'h0000, 0, 0,  1, 0, 0, 0);  // 11 unlocks, clears count
    addVec(1, 16'h0000, 0, 0,  1, 0, 0, 0);  // 12 entered ignored in UNLOCKED
    addVec(0, 16'h0000, 0, 0,  1, 0, 0, 0);  // 13
    addVec(0, 16'h0000, 0, 1,  1, 0, 0, 1);  // 14 -> PROGRAM
    addVec(1, 16'h9999, 1, 0,  0, 0, 0, 1);  // 15 lock beats entered
    addVec(1, 16'h9999, 0, 0,  0, 0, 0, 0);  // 16
    addVec(0, 16'h0000, 0, 0,  0, 0, 1, 1);  // 17 9999 was not stored
    addVec(1, 16'h5678, 0, 0,  0, 0, 1, 0);  // 18
    addVec(0, 16'h0000, 0, 0,  1, 0, 0, 0);  // 19
    addVec(0, 16'h0000, 1, 0,  0, 0, 0, 1);  // 20 relock
    addVec(0, 16'h0000, 1, 1,  0, 0, 0, 0);  // 21 LOCKED ignores lock/program

    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("resetState", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].entered, vecs[i].code, vecs[i].lock, vecs[i].prog);
      checkOutput($sformatf("vec%0d", i), vecs[i].expU, vecs[i].expL, vecs[i].expF, vecs[i].expR);
    end

    // Stored code is 5678 here; reset during a lockout must restore 1234 and clear everything.
    applyStimulus(1, 16'h0000, 0, 0); checkOutput("rstSeqChk1", 0, 0, 0, 0);
    applyStimulus(0, 16'h0000, 0, 0); checkOutput("rstSeqFail1", 0, 0, 1, 1);
    applyStimulus(1, 16'h0000, 0, 0); checkOutput("rstSeqChk2", 0, 0, 1, 0);
    applyStimulus(0, 16'h0000, 0, 0); checkOutput("rstSeqFail2", 0, 0, 2, 1);
    applyStimulus(1, 16'h0000, 0, 0); checkOutput("rstSeqChk3", 0, 0, 2, 0);
    applyStimulus(0, 16'h0000, 0, 0); checkOutput("rstSeqLockout", 0, 1, 3, 0);
    applyStimulus(0, 16'h0000, 0, 0);
    applyStimulus(0, 16'h0000, 0, 0); checkOutput("rstSeqMidLockout", 0, 1, 3, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rstSeqAfterReset", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1, 16'h1234, 0, 0); checkOutput("rstSeqDefaultChk", 0, 0, 0, 0);
    applyStimulus(0, 16'h0000, 0, 0); checkOutput("rstSeqDefaultOpens", 1, 0, 0, 0);
    applyStimulus(0, 16'h0000, 1, 0); checkOutput("rstSeqRelock", 0, 0, 0, 1);

    // Three failures -> lockout for LOCKOUT_CYCLES; a correct code during lockout is ignored.
    for (int k = 0; k < MAX_TRIES; k++) begin
      applyStimulus(1, 16'h0000, 0, 0);
      applyStimulus(0, 16'h0000, 0, 0);
      if (k < MAX_TRIES - 1) checkOutput($sformatf("lockoutFail%0d", k + 1), 0, 0, 2'(k + 1), 1);
    end
    checkOutput("lockoutEnter", 0, 1, 3, 0);
    cnt  = 1;
    done = 0;
    for (int k = 0; k < 50 && !done; k++) begin
      applyStimulus(k == 1, 16'h1234, k == 2, k == 3);
      if (bus.lockout_o === 1'b1) cnt++;
      else done = 1;
    end
    checkValue("lockoutExited", int'(done), 1);
    checkValue("lockoutDwell", cnt, LOCKOUT_CYCLES);
    checkOutput("lockoutExitState", 0, 0, 0, 1);
    applyStimulus(0, 16'h0000, 0, 0); checkOutput("lockoutAfterExit", 0, 0, 0, 0);

    // Unlock and idle: auto-relock after exactly UNLOCK_CYCLES.
    applyStimulus(1, 16'h1234, 0, 0); checkOutput("dwellChk", 0, 0, 0, 0);
    applyStimulus(0, 16'h0000, 0, 0); checkOutput("dwellOpen", 1, 0, 0, 0);
    cnt  = 1;
    done = 0;
    for (int k = 0; k < 60 && !done; k++) begin
      applyStimulus(0, 16'h0000, 0, 0);
      if (bus.unlocked_o === 1'b1) cnt++;
      else done = 1;
    end
    checkValue("dwellExited", int'(done), 1);
    checkValue("dwellLength", cnt, UNLOCK_CYCLES);
    checkOutput("dwellRelockState", 0, 0, 0, 1);
    applyStimulus(0, 16'h0000, 0, 0); checkOutput("dwellAfterRelock", 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
